// File: rtl/fp32_div_pkg.sv
// Shared types and widths for the FP32 mantissa divider.
// The optional feature FP32_MANT_DIV_EARLY_TERM_EN is handled in fp32_mant_divider.
package fp32_div_pkg;

   localparam int MANT_W = 24;
   localparam int Q_W    = 26;
   localparam int R_W    = MANT_W + 1;
   localparam int CNT_W  = 5;

   localparam logic [CNT_W-1:0] ITER_LAST = 5'd25;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } div_state_e;

endpackage

// File: rtl/mant_div_iter_counter.sv
// Iteration down counter for the mantissa divider: synchronous load of ITER_LAST,
// decrement on enable, and a flag that marks the final iteration.
module mant_div_iter_counter
   import fp32_div_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] count_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = ITER_LAST;
      end else if (en_i) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);

endmodule

// File: rtl/fp32_mant_divider.sv
// Restoring divider for 24-bit FP32 mantissas, one quotient bit per clock.
// Define FP32_MANT_DIV_EARLY_TERM_EN to finish as soon as the partial remainder reaches zero.
module fp32_mant_divider
   import fp32_div_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [MANT_W-1:0] dividend_mant,
   input  logic [MANT_W-1:0] divisor_mant,
   output logic              busy,
   output logic              done,
   output logic [Q_W-1:0]    quotient,
   output logic              sticky,
   output logic              dz
);

   div_state_e        state_q, state_d;
   logic [R_W-1:0]    r_q, r_d;
   logic [MANT_W-1:0] div_q, div_d;
   logic [Q_W-1:0]    q_q, q_d;
   logic              sticky_q, sticky_d;
   logic              dz_q, dz_d;
   logic              busy_q, done_q;

   logic              cnt_load, cnt_en, cnt_zero;
   logic [CNT_W-1:0]  cnt_value;
   logic              qbit;
   logic [R_W-1:0]    rn;
   logic [Q_W-1:0]    q_step;

   mant_div_iter_counter u_iter_counter (
      .clk     (clk),
      .reset   (reset),
      .load_i  (cnt_load),
      .en_i    (cnt_en),
      .count_o (cnt_value),
      .zero_o  (cnt_zero)
   );

`ifndef FP32_MANT_DIV_EARLY_TERM_EN
   logic unused_cnt;
   assign unused_cnt = ^cnt_value;
`endif

   // R stays below twice the divisor, so the extra MSB absorbs the doubling.
   assign qbit   = (r_q >= {1'b0, div_q});
   assign rn     = qbit ? (r_q - {1'b0, div_q}) : r_q;
   assign q_step = {q_q[Q_W-2:0], qbit};

   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      div_d    = div_q;
      q_d      = q_q;
      sticky_d = sticky_q;
      dz_d     = dz_q;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               div_d = divisor_mant;
               if (divisor_mant == '0) begin
                  q_d      = '1;
                  sticky_d = 1'b0;
                  dz_d     = 1'b1;
                  state_d  = DONE;
               end else begin
                  r_d      = {1'b0, dividend_mant};
                  q_d      = '0;
                  sticky_d = 1'b0;
                  dz_d     = 1'b0;
                  cnt_load = 1'b1;
                  state_d  = CALC;
               end
            end
         end
         CALC: begin
            q_d    = q_step;
            r_d    = rn << 1;
            cnt_en = 1'b1;
`ifdef FP32_MANT_DIV_EARLY_TERM_EN
            // Remaining quotient bits are all zero once the remainder vanishes.
            if (rn == '0) begin
               q_d      = q_step << cnt_value;
               sticky_d = 1'b0;
               state_d  = DONE;
            end else
`endif
            if (cnt_zero) begin
               sticky_d = |rn;
               state_d  = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         r_q      <= '0;
         div_q    <= '0;
         q_q      <= '0;
         sticky_q <= 1'b0;
         dz_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         r_q      <= r_d;
         div_q    <= div_d;
         q_q      <= q_d;
         sticky_q <= sticky_d;
         dz_q     <= dz_d;
         busy_q   <= (state_d == CALC);
         done_q   <= (state_d == DONE);
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign quotient = q_q;
   assign sticky   = sticky_q;
   assign dz       = dz_q;

endmodule
